// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) engine.
// Produces a 2*WIDTH result split into result_hi/result_lo with a one-cycle done pulse.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned AccW = 2 * WIDTH + 2;

  typedef enum logic [1:0] {StIdle, StRun, StFixup, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              op_q, op_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic              b_zero_q, b_zero_d;
  logic              a_neg_q, a_neg_d;
  logic              q_neg_q, q_neg_d;
  logic [WIDTH:0]    m_q, m_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]  res_hi_q, res_hi_d;
  logic [WIDTH-1:0]  res_lo_q, res_lo_d;
  logic              dbz_q, dbz_d;

  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [WIDTH:0]    upper, sum;
  logic [WIDTH:0]    rem_sh, trial;
  logic [WIDTH-1:0]  quo, rem;

  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_zero_d = b_zero_q;
    a_neg_d  = a_neg_q;
    q_neg_d  = q_neg_q;
    m_d      = m_q;
    acc_d    = acc_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    dbz_d    = dbz_q;
    upper    = acc_q[AccW-1:WIDTH+1];
    sum      = upper;
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    trial    = rem_sh - m_q;
    quo      = acc_q[WIDTH-1:0];
    rem      = acc_q[2*WIDTH-1:WIDTH];

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d     = op;
          a_d      = a;
          b_zero_d = (b == '0);
          a_neg_d  = a[WIDTH-1];
          q_neg_d  = a[WIDTH-1] ^ b[WIDTH-1];
          cnt_d    = CntW'(WIDTH - 1);
          if (op) begin
            // DIV layout: {pad, remainder[W:0], dividend/quotient[W-1:0]}
            m_d   = {1'b0, b_mag};
            acc_d = {{(WIDTH + 2){1'b0}}, a_mag};
          end else begin
            // MUL layout: {partial[W:0], multiplier[W-1:0], booth bit}; partial is
            // one bit wider so subtracting the most-negative multiplicand cannot wrap.
            m_d   = {a[WIDTH-1], a};
            acc_d = {{(WIDTH + 1){1'b0}}, b, 1'b0};
          end
          state_d = StRun;
        end
      end
      StRun: begin
        if (op_q) begin
          if (!trial[WIDTH]) begin
            acc_d = {1'b0, trial, acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {1'b0, rem_sh, acc_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          case (acc_q[1:0])
            2'b01:   sum = upper + m_q;
            2'b10:   sum = upper - m_q;
            default: sum = upper;
          endcase
          acc_d = {sum[WIDTH], sum, acc_q[WIDTH:1]};
        end
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == '0) begin
          state_d = StFixup;
        end
      end
      StFixup: begin
        if (!op_q) begin
          res_hi_d = acc_q[2*WIDTH:WIDTH+1];
          res_lo_d = acc_q[WIDTH:1];
          dbz_d    = 1'b0;
        end else if (b_zero_q) begin
          res_hi_d = a_q;
          res_lo_d = '1;
          dbz_d    = 1'b1;
        end else begin
          res_lo_d = q_neg_q ? -quo : quo;
          res_hi_d = a_neg_q ? -rem : rem;
          dbz_d    = 1'b0;
        end
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      a_q      <= '0;
      b_zero_q <= 1'b0;
      a_neg_q  <= 1'b0;
      q_neg_q  <= 1'b0;
      m_q      <= '0;
      acc_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_zero_q <= b_zero_d;
      a_neg_q  <= a_neg_d;
      q_neg_q  <= q_neg_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign result_hi   = res_hi_q;
  assign result_lo   = res_lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed MUL/DIV vectors, latency, handshake
// and reset-abort behaviour.
module tb_mul_div_unit;

  localparam int unsigned W = 32;
  // Edges after the accepting edge until done is visible: W RUN + FIXUP + DONE entry,
  // i.e. done is visible after the 34th edge counting the accepting edge.
  localparam int unsigned Lat = W + 1;

  logic         clock;
  logic         clear;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result_hi;
  logic [W-1:0] result_lo;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result_hi   (result_hi),
    .result_lo   (result_lo),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse start for one edge, scramble operands mid-run, wait for done (bounded).
  task automatic issue(input logic o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       output int lat, output logic busy_run);
    @(negedge clock);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    @(posedge clock);
    #1;
    start    = 1'b0;
    a        = $urandom;
    b        = $urandom;
    busy_run = busy;
    lat      = 0;
    while (!done && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic run_check(input string tag, input logic o, input logic [W-1:0] av,
                           input logic [W-1:0] bv, input logic [W-1:0] exp_hi,
                           input logic [W-1:0] exp_lo, input logic exp_dbz);
    int   lat;
    logic busy_run;
    issue(o, av, bv, lat, busy_run);
    check_eq({tag, "_busy_run"}, 64'(busy_run), 64'd1);
    check_eq({tag, "_lat"}, 64'(lat), 64'(Lat));
    check_eq({tag, "_hi"}, 64'(result_hi), 64'(exp_hi));
    check_eq({tag, "_lo"}, 64'(result_lo), 64'(exp_lo));
    check_eq({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
    @(posedge clock);
    #1;
    check_eq({tag, "_busy_after"}, 64'({busy, done}), 64'd0);
  endtask

  initial begin
    int   lat;
    int   n_done;
    int   first_done;
    int   second_done;
    logic busy_run;

    clear = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_hi", 64'(result_hi), 64'd0);
    check_eq("rst_lo", 64'(result_lo), 64'd0);
    check_eq("rst_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clock);
    clear = 1'b1;

    run_check("mul_m7x6", 1'b0, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0);
    run_check("mul_minmin", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
    run_check("mul_maxxm1", 1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'h8000_0001, 1'b0);
    run_check("div_m7d2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_check("div_100d7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_check("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_check("div_zero", 1'b1, 32'd100, 32'd0, 32'h64, 32'hFFFF_FFFF, 1'b1);
    run_check("div_clr_dbz", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

    // Held start: accepts at edge 1, done after edge 34, idle after 35, re-accepts at 36.
    @(negedge clock);
    start       = 1'b1;
    op          = 1'b0;
    a           = 32'd3;
    b           = 32'd5;
    n_done      = 0;
    first_done  = 0;
    second_done = 0;
    for (int i = 1; i <= 75; i++) begin
      @(posedge clock);
      #1;
      if ((i >= 5 && i <= 20) || (i >= 45 && i <= 60)) begin
        a = 32'd7;
        b = 32'd9;
      end else begin
        a = 32'd3;
        b = 32'd5;
      end
      if (done) begin
        n_done++;
        if (n_done == 1) first_done = i;
        if (n_done == 2) second_done = i;
        check_eq("hs_res", {result_hi, result_lo}, 64'd15);
      end
    end
    start = 1'b0;
    check_eq("hs_count", 64'(n_done), 64'd2);
    check_eq("hs_first", 64'(first_done), 64'd34);
    check_eq("hs_second", 64'(second_done), 64'd69);
    repeat (40) @(posedge clock);

    // Abort: set div_by_zero first so the reset clearing it is observable.
    run_check("div_zero2", 1'b1, 32'd100, 32'd0, 32'h64, 32'hFFFF_FFFF, 1'b1);
    @(negedge clock);
    start = 1'b1;
    op    = 1'b1;
    a     = 32'd100;
    b     = 32'd7;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    clear = 1'b0;
    @(posedge clock);
    #1;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_outs", {30'd0, done, div_by_zero, result_hi}, 64'd0);
    check_eq("abort_lo", 64'(result_lo), 64'd0);
    @(negedge clock);
    clear  = 1'b1;
    n_done = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (done) n_done++;
    end
    check_eq("abort_no_done", 64'(n_done), 64'd0);

    // Reset and start on the same edge: start is dropped.
    @(negedge clock);
    clear = 1'b0;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    clear = 1'b1;
    check_eq("rst_start_busy", 64'(busy), 64'd0);

    issue(1'b1, 32'd100, 32'd7, lat, busy_run);
    check_eq("post_busy_run", 64'(busy_run), 64'd1);
    check_eq("post_lat", 64'(lat), 64'(Lat));
    check_eq("post_res", {result_hi, result_lo}, {32'd2, 32'd14});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
